// File: rtl/mem_access_unit_pkg.sv
// Shared load/store decode types, LSU state encoding and bus transfer-size codes.
package mem_access_unit_pkg;
   typedef enum logic [2:0] {
      LS_NONE    = 3'd0,
      LS_BTYE    = 3'd1,
      LS_BTYE_U  = 3'd2,
      LS_HALFW   = 3'd3,
      LS_HALFW_U = 3'd4,
      LS_WORD    = 3'd5
   } ls_flag_t;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] MSIZE1 = 3'd0;
   localparam logic [2:0] MSIZE2 = 3'd1;
   localparam logic [2:0] MSIZE4 = 3'd2;
endpackage

// File: rtl/mem_access_unit_ls_data_align.sv
// Combinational lane steering: store strobe/replicated data/size, and load extraction with extension.
module ls_data_align
   import mem_access_unit_pkg::*;
(
   input  ls_flag_t    st_flag,
   input  logic [1:0]  st_off,
   input  logic [31:0] wdata,
   output logic [3:0]  st_strobe,
   output logic [31:0] st_data,
   output logic [2:0]  st_size,
   input  ls_flag_t    ld_flag,
   input  logic [1:0]  ld_off,
   input  logic [31:0] raw,
   output logic [31:0] ld_data
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      st_strobe = 4'b0000;
      st_data   = wdata;
      st_size   = MSIZE4;
      case (st_flag)
         LS_BTYE, LS_BTYE_U: begin
            st_strobe = 4'b0001 << st_off;
            st_data   = {4{wdata[7:0]}};
            st_size   = MSIZE1;
         end
         LS_HALFW, LS_HALFW_U: begin
            st_strobe = 4'b0011 << {st_off[1], 1'b0};
            st_data   = {2{wdata[15:0]}};
            st_size   = MSIZE2;
         end
         LS_WORD: st_strobe = 4'b1111;
         default: st_strobe = 4'b0000;
      endcase
   end

   // Halfword lane ignores addr[0]; unaligned halfwords fall back to the containing half.
   assign lane_b = raw[{ld_off, 3'b000} +: 8];
   assign lane_h = raw[{ld_off[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = raw;
      case (ld_flag)
         LS_BTYE:    ld_data = {{24{lane_b[7]}}, lane_b};
         LS_BTYE_U:  ld_data = {24'b0, lane_b};
         LS_HALFW:   ld_data = {{16{lane_h[15]}}, lane_h};
         LS_HALFW_U: ld_data = {16'b0, lane_h};
         default:    ld_data = raw;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage LSU: one dbus transaction per load/store, stalls the pipe until the registered result.
// Optional LSU_ALIGN_CHECK_EN: misaligned halfword/word accesses raise misalign instead of issuing.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  ls_flag_t    ls_flag,
   input  logic        mem_write_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [2:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data
);
   lsu_state_t  state;
   ls_flag_t    req_flag;
   logic        req_write;
   logic        misalign_cond;
   logic        start;
   logic [3:0]  al_strobe;
   logic [31:0] al_data;
   logic [2:0]  al_size;
   logic [31:0] ld_ext;

`ifdef LSU_ALIGN_CHECK_EN
   assign misalign_cond = in_valid && (ls_flag != LS_NONE) &&
                          ((((ls_flag == LS_HALFW) || (ls_flag == LS_HALFW_U)) && addr[0]) ||
                           ((ls_flag == LS_WORD) && (addr[1:0] != 2'b00)));
   assign misalign = (state == LSU_IDLE) && misalign_cond;
`else
   assign misalign_cond = 1'b0;
   assign misalign      = 1'b0;
`endif

   assign start = in_valid && (ls_flag != LS_NONE) && !misalign_cond;
   // Stall covers the data_ok cycle too: the result is only visible once registered.
   assign stall = (state == LSU_REQ) || (state == LSU_WAIT) || ((state == LSU_IDLE) && start);

   ls_data_align u_align (
      .st_flag   (ls_flag),
      .st_off    (addr[1:0]),
      .wdata     (wdata),
      .st_strobe (al_strobe),
      .st_data   (al_data),
      .st_size   (al_size),
      .ld_flag   (req_flag),
      .ld_off    (dreq_addr[1:0]),
      .raw       (dresp_data),
      .ld_data   (ld_ext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LSU_IDLE;
         dreq_valid  <= 1'b0;
         done        <= 1'b0;
         rdata       <= 32'b0;
         dreq_addr   <= 32'b0;
         dreq_data   <= 32'b0;
         dreq_strobe <= 4'b0;
         dreq_size   <= MSIZE1;
         req_flag    <= LS_NONE;
         req_write   <= 1'b0;
      end else begin
         case (state)
            LSU_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dreq_addr   <= addr;
                  dreq_size   <= al_size;
                  dreq_strobe <= mem_write_en ? al_strobe : 4'b0000;
                  dreq_data   <= al_data;
                  req_flag    <= ls_flag;
                  req_write   <= mem_write_en;
                  dreq_valid  <= 1'b1;
                  state       <= LSU_REQ;
               end
            end
            LSU_REQ: begin
               if (dresp_addr_ok) begin
                  dreq_valid <= 1'b0;
                  if (dresp_data_ok) begin
                     if (!req_write) rdata <= ld_ext;
                     done  <= 1'b1;
                     state <= LSU_DONE;
                  end else begin
                     state <= LSU_WAIT;
                  end
               end
            end
            LSU_WAIT: begin
               if (dresp_data_ok) begin
                  if (!req_write) rdata <= ld_ext;
                  done  <= 1'b1;
                  state <= LSU_DONE;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= LSU_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: randomized loads/stores vs. a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   ls_flag_t    ls_flag;
   logic        mem_write_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        misalign;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;

`ifdef LSU_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   mem_access_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .ls_flag(ls_flag),
      .mem_write_en(mem_write_en), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic        we;
   } req_t;
   typedef struct {
      logic        is_load;
      logic [31:0] rdata;
   } rsp_t;

   req_t        req_q[$];
   rsp_t        rsp_q[$];
   logic [31:0] bus_q[$];
   int          cfg_aok = 0;
   int          cfg_dok = 1;
   bit          bus_auto = 1'b1;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int nbytes(ls_flag_t f);
      if (f == LS_BTYE || f == LS_BTYE_U) return 1;
      if (f == LS_HALFW || f == LS_HALFW_U) return 2;
      return 4;
   endfunction

   function automatic bit misaligned(ls_flag_t f, logic [31:0] a);
      return ALIGN_CHK && ((a % nbytes(f)) != 0);
   endfunction

   // Reference: view the bus word as four bytes, pick the naturally aligned group, extend arithmetically.
   function automatic logic [31:0] model_load(ls_flag_t f, logic [31:0] a, logic [31:0] raw);
      int b[4];
      int n, base, v;
      for (int i = 0; i < 4; i++) b[i] = int'((raw >> (8 * i)) & 32'hFF);
      n    = nbytes(f);
      base = int'(a % 4) - (int'(a % 4) % n);
      if (n == 4) return raw;
      v = (n == 1) ? b[base] : b[base] + 256 * b[base + 1];
      if (f == LS_BTYE && v >= 128) v = v - 256;
      if (f == LS_HALFW && v >= 32768) v = v - 65536;
      return 32'(v);
   endfunction

   function automatic req_t model_req(ls_flag_t f, logic we, logic [31:0] a, logic [31:0] wd);
      req_t r;
      int n, base;
      n    = nbytes(f);
      base = int'(a % 4) - (int'(a % 4) % n);
      r.addr = a;
      r.we   = we;
      r.size = (n == 1) ? MSIZE1 : (n == 2) ? MSIZE2 : MSIZE4;
      for (int i = 0; i < 4; i++) begin
         r.strobe[i]    = we && (i >= base) && (i < base + n);
         r.data[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      return r;
   endfunction

   task automatic expect_op(ls_flag_t f, logic we, logic [31:0] a, logic [31:0] wd, logic [31:0] raw);
      rsp_t s;
      req_q.push_back(model_req(f, we, a, wd));
      s.is_load = !we;
      s.rdata   = model_load(f, a, raw);
      rsp_q.push_back(s);
      bus_q.push_back(raw);
   endtask

   task automatic drive(ls_flag_t f, logic we, logic [31:0] a, logic [31:0] wd);
      in_valid = 1'b1; ls_flag = f; mem_write_en = we; addr = a; wdata = wd;
   endtask

   // Bus responder: withholds addr_ok cfg_aok cycles, then data_ok cfg_dok cycles later (0 = same cycle).
   initial begin
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'b0;
      forever begin
         @(posedge clk); #1;
         if (bus_auto && dreq_valid) begin
            repeat (cfg_aok) begin @(posedge clk); #1; end
            dresp_data    = (bus_q.size() != 0) ? bus_q.pop_front() : $urandom;
            dresp_addr_ok = 1'b1;
            dresp_data_ok = (cfg_dok == 0);
            @(posedge clk); #1;
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            if (cfg_dok > 0) begin
               repeat (cfg_dok - 1) begin @(posedge clk); #1; end
               dresp_data_ok = 1'b1;
               @(posedge clk); #1;
               dresp_data_ok = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted request and every completion is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && dreq_valid && dresp_addr_ok) begin
            if (req_q.size() == 0) chk("unexpected_req", 1, 0);
            else begin
               req_t e;
               e = req_q.pop_front();
               chk("req_addr", dreq_addr, e.addr);
               chk("req_size", 32'(dreq_size), 32'(e.size));
               chk("req_strobe", 32'(dreq_strobe), 32'(e.strobe));
               if (e.we) chk("req_data", dreq_data, e.data);
            end
         end
         if (done) begin
            if (rsp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               rsp_t s;
               s = rsp_q.pop_front();
               if (s.is_load) chk("load_rdata", rdata, s.rdata);
            end
         end
      end
   end

   // Cycle-exact op: stall high for cycles 0..n-1, done at n = 2+d+k, request stable while withheld.
   task automatic timed_op(string nm, ls_flag_t f, logic we, logic [31:0] a, logic [31:0] wd,
                           logic [31:0] raw, int d, int k);
      req_t e;
      int   n;
      cfg_aok = d; cfg_dok = k;
      e = model_req(f, we, a, wd);
      expect_op(f, we, a, wd, raw);
      drive(f, we, a, wd);
      n = 2 + d + k;
      for (int c = 0; c <= n; c++) begin
         @(negedge clk);
         chk({nm, "_stall"}, 32'(stall), 32'(c < n));
         chk({nm, "_done"}, 32'(done), 32'(c == n));
         if (c >= 1 && c <= 1 + d) begin
            chk({nm, "_vld"}, 32'(dreq_valid), 1);
            chk({nm, "_addr"}, dreq_addr, e.addr);
            chk({nm, "_strobe"}, 32'(dreq_strobe), 32'(e.strobe));
         end
         if (c == n && !we) chk({nm, "_rdata"}, rdata, model_load(f, a, raw));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic rand_op(int idx);
      ls_flag_t    f;
      logic        we;
      logic [31:0] a, wd, raw;
      bit          got;
      case ($urandom_range(0, 4))
         0: f = LS_BTYE;
         1: f = LS_BTYE_U;
         2: f = LS_HALFW;
         3: f = LS_HALFW_U;
         default: f = LS_WORD;
      endcase
      we  = ($urandom_range(0, 2) == 0);
      a   = $urandom;
      wd  = $urandom;
      raw = $urandom;
      if (misaligned(f, a)) begin
         drive(f, we, a, wd);
         @(negedge clk);
         chk("rand_misalign", 32'(misalign), 1);
         chk("rand_misalign_stall", 32'(stall), 0);
         @(posedge clk); #1;
         chk("rand_misalign_vld", 32'(dreq_valid), 0);
         in_valid = 1'b0;
         return;
      end
      cfg_aok = $urandom_range(0, 3);
      cfg_dok = $urandom_range(0, 2);
      expect_op(f, we, a, wd, raw);
      drive(f, we, a, wd);
      got = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
         @(negedge clk);
         if (t == 0) chk("rand_no_misalign", 32'(misalign), 0);
         if (done) got = 1'b1;
      end
      if (!got) $display("op %0d timed out", idx);
      chk("rand_done_seen", 32'(got), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; ls_flag = LS_NONE; mem_write_en = 1'b0;
      addr = 32'b0; wdata = 32'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_vld", 32'(dreq_valid), 0);
      chk("rst_misalign", 32'(misalign), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr", dreq_addr, 0);
      chk("rst_data", dreq_data, 0);
      chk("rst_strobe", 32'(dreq_strobe), 0);
      chk("rst_size", 32'(dreq_size), 32'(MSIZE1));
      @(posedge clk); #1;
      reset = 1'b0;

      timed_op("lw_zw", LS_WORD, 1'b0, 32'h8000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1);
      timed_op("lb3", LS_BTYE, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 1);
      timed_op("lbu3", LS_BTYE_U, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 1);
      timed_op("lh2", LS_HALFW, 1'b0, 32'h8000_0002, 32'h0, 32'h80FF_0000, 0, 1);
      timed_op("sb2", LS_BTYE, 1'b1, 32'h1000_0002, 32'h1234_5678, 32'h0, 0, 1);
      timed_op("sh2", LS_HALFW, 1'b1, 32'h1000_0002, 32'h1234_5678, 32'h0, 0, 1);
      timed_op("lw_bp4", LS_WORD, 1'b0, 32'h8000_0010, 32'h0, 32'h0BAD_F00D, 4, 1);
      timed_op("lw_same", LS_WORD, 1'b0, 32'h8000_0020, 32'h0, 32'h1357_9BDF, 0, 0);

`ifdef LSU_ALIGN_CHECK_EN
      drive(LS_WORD, 1'b0, 32'h8000_0002, 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mis_flag", 32'(misalign), 1);
         chk("mis_stall", 32'(stall), 0);
         chk("mis_vld", 32'(dreq_valid), 0);
         chk("mis_done", 32'(done), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
`else
      timed_op("lw_unal", LS_WORD, 1'b0, 32'h8000_0002, 32'h0, 32'hA5A5_0F0F, 0, 1);
`endif

      // Reset while waiting for data, then a late data_ok arrives in IDLE.
      bus_auto = 1'b0;
      req_q.push_back(model_req(LS_WORD, 1'b0, 32'h8000_2000, 32'h0));
      drive(LS_WORD, 1'b0, 32'h8000_2000, 32'h0);
      @(posedge clk); #1;
      dresp_addr_ok = 1'b1;
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0;
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rstw_vld", 32'(dreq_valid), 0);
      chk("rstw_stall", 32'(stall), 0);
      @(posedge clk); #1;
      dresp_data = 32'hCAFE_F00D;
      dresp_data_ok = 1'b1;
      @(negedge clk);
      chk("stray_done0", 32'(done), 0);
      @(posedge clk); #1;
      dresp_data_ok = 1'b0;
      @(negedge clk);
      chk("stray_done1", 32'(done), 0);
      chk("stray_rdata", rdata, 0);
      @(posedge clk); #1;
      bus_auto = 1'b1;
      timed_op("lw_after_rst", LS_HALFW_U, 1'b0, 32'h8000_3002, 32'h0, 32'hFEDC_BA98, 1, 1);

      for (int i = 0; i < 40; i++) begin
         rand_op(i);
         if ($urandom_range(0, 2) == 0) begin
            in_valid = $urandom_range(0, 1);
            ls_flag  = LS_NONE;
            @(negedge clk);
            chk("none_stall", 32'(stall), 0);
            chk("none_vld", 32'(dreq_valid), 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
         end
      end

      repeat (5) @(posedge clk);
      chk("req_q_drained", 32'(req_q.size()), 0);
      chk("rsp_q_drained", 32'(rsp_q.size()), 0);
      chk("bus_q_drained", 32'(bus_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
